// File: rtl/mem_lcd_interface_if.sv
// Bus bundle between the microprogrammed controller / external storage and the
// memory/LCD access sequencer.
//  Controller side : rd_req, wr_req, addr, wdata -> ; <- rdata, wait_
//  Memory side     : <- mem_addr, mem_wdata, mem_re, mem_we ; mem_rdata ->
//  LCD side        : <- lcd_rs, lcd_e, lcd_data
// master = controller/storage environment, slave = the sequencer.
interface mem_lcd_interface_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              wait_;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              lcd_rs;
  logic              lcd_e;
  logic [7:0]        lcd_data;

  modport master (
    output rd_req, wr_req, addr, wdata, mem_rdata,
    input  rdata, wait_, mem_addr, mem_wdata, mem_re, mem_we, lcd_rs, lcd_e, lcd_data
  );

  modport slave (
    input  rd_req, wr_req, addr, wdata, mem_rdata,
    output rdata, wait_, mem_addr, mem_wdata, mem_re, mem_we, lcd_rs, lcd_e, lcd_data
  );
endinterface

// File: rtl/mem_lcd_interface.sv
// Memory/LCD access sequencer.
// Accepts read/write strobes from the controller, runs a MEM_LAT-cycle access to
// synchronous memory or an LCD write cycle (setup / E pulse / hold), and drives
// wait_ to stall the controller until the one-cycle DONE state.
// Ports: clk (rising edge), reset (async, active high), bus (slave modport of
// mem_lcd_interface_if carrying controller, memory and LCD signals).
module mem_lcd_interface #(
  parameter int          ADDR_W    = 12,
  parameter int          DATA_W    = 16,
  parameter int          MEM_LAT   = 2,
  parameter int unsigned LCD_BASE  = 'hF00,
  parameter int          LCD_SETUP = 1,
  parameter int          LCD_PULSE = 4,
  parameter int          LCD_HOLD  = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_lcd_interface_if.slave  bus
);
  localparam int MAX_AB = (MEM_LAT > LCD_SETUP) ? MEM_LAT : LCD_SETUP;
  localparam int MAX_CD = (LCD_PULSE > LCD_HOLD) ? LCD_PULSE : LCD_HOLD;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  // counter holds (duration-1) down to 0
  localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0]  CNT_MEM = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_SU  = CNT_W'(LCD_SETUP - 1);
  localparam logic [CNT_W-1:0]  CNT_EN  = CNT_W'(LCD_PULSE - 1);
  localparam logic [CNT_W-1:0]  CNT_HD  = CNT_W'(LCD_HOLD - 1);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(LCD_BASE);

  typedef enum logic [2:0] {IDLE, MEM, LCD_SU, LCD_EN, LCD_HD, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rs_q, rs_d;
  logic [7:0]        ldata_q, ldata_d;
  logic              wait_c, re_c, we_c, e_c;
  logic              req;

  assign req = bus.rd_req | bus.wr_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rs_q    <= 1'b0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rs_q    <= rs_d;
      ldata_q <= ldata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rs_d    = rs_q;
    ldata_d = ldata_q;
    wait_c  = 1'b0;
    re_c    = 1'b0;
    we_c    = 1'b0;
    e_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        wait_c = req;
        if (req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          is_rd_d = bus.rd_req;  // read wins when both strobes are set
          if (bus.addr >= BASE_A) begin
            if (bus.rd_req) begin
              rdata_d = '0;      // LCD region is write-only
              state_d = DONE;
            end else begin
              rs_d    = bus.addr[0];
              ldata_d = bus.wdata[7:0];
              cnt_d   = CNT_SU;
              state_d = LCD_SU;
            end
          end else begin
            cnt_d   = CNT_MEM;
            state_d = MEM;
          end
        end
      end
      MEM: begin
        wait_c = 1'b1;
        re_c   = is_rd_q;
        we_c   = ~is_rd_q;
        if (cnt_q == '0) begin
          if (is_rd_q) rdata_d = bus.mem_rdata;
          state_d = DONE;
        end
      end
      LCD_SU: begin
        wait_c = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_EN;
          state_d = LCD_EN;
        end
      end
      LCD_EN: begin
        wait_c = 1'b1;
        e_c    = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_HD;
          state_d = LCD_HD;
        end
      end
      LCD_HD: begin
        wait_c = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;  // requests here are ignored
      default: state_d = IDLE;
    endcase
  end

  // strobes decode straight from state so reset kills them without a clock
  assign bus.wait_     = wait_c;
  assign bus.mem_re    = re_c;
  assign bus.mem_we    = we_c;
  assign bus.lcd_e     = e_c;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_data  = ldata_q;
endmodule
